// File: rtl/core_seq_pkg.sv
// Shared types for the core sequencer: FSM states, opcodes, branch conditions,
// ALU op codes and the 46-bit control word layout driven to the datapath.
package core_seq_pkg;

  localparam int IR_W = 16;
  localparam int CW_W = 46;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXECUTE = 3'd2,
    ST_HALT    = 3'd3
  } seq_state_e;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_LDI  = 4'h9;
  localparam logic [3:0] OP_LD   = 4'hA;
  localparam logic [3:0] OP_ST   = 4'hB;
  localparam logic [3:0] OP_BR   = 4'hC;
  localparam logic [3:0] OP_ILL0 = 4'hD;
  localparam logic [3:0] OP_ILL1 = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] BR_ALWAYS = 3'd0;
  localparam logic [2:0] BR_Z      = 3'd1;
  localparam logic [2:0] BR_N      = 3'd2;
  localparam logic [2:0] BR_C      = 3'd3;
  localparam logic [2:0] BR_NZ     = 3'd4;

  localparam logic [3:0] ALU_PASS_B = 4'h0;
  localparam logic [3:0] ALU_ADD    = 4'h1;

  typedef struct packed {
    logic        rf_we;
    logic [2:0]  rd;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [3:0]  alu_op;
    logic        b_imm;
    logic [15:0] imm16;
    logic        flags_we;
    logic        mem_we;
    logic        mem_re;
    logic [11:0] rsvd;
  } cw_t;

  // Codes 5-7 are reserved and never branch.
  function automatic logic br_taken(input logic [2:0] cond, input logic c, input logic z,
                                    input logic n);
    case (cond)
      BR_ALWAYS: br_taken = 1'b1;
      BR_Z:      br_taken = z;
      BR_N:      br_taken = n;
      BR_C:      br_taken = c;
      BR_NZ:     br_taken = ~z;
      default:   br_taken = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/core_seq_if.sv
// ROM fetch port and datapath control/flag/memory-ack bundle of the core sequencer.
interface core_seq_if
  import core_seq_pkg::*;
#(
  parameter int PC_W = 8
);
  logic [PC_W-1:0] rom_addr;
  logic [IR_W-1:0] rom_data;
  cw_t             cw;
  logic            c_flag;
  logic            z_flag;
  logic            n_flag;
  logic            mem_ack;

  modport master (output rom_addr, output cw,
                  input rom_data, input c_flag, input z_flag, input n_flag, input mem_ack);
  modport slave  (input rom_addr, input cw,
                  output rom_data, output c_flag, output z_flag, output n_flag, output mem_ack);
endinterface

// File: rtl/core_decoder.sv
// Combinational instruction decode: ir -> control word plus class flags.
module core_decoder
  import core_seq_pkg::*;
(
  input  logic [IR_W-1:0] ir,
  output cw_t             cw,
  output logic            illegal,
  output logic            is_mem,
  output logic            is_br
);
  logic [3:0] op;
  logic [2:0] rd, ra, rb;

  assign op = ir[15:12];
  assign rd = ir[11:9];
  assign ra = ir[8:6];
  assign rb = ir[5:3];

  // Fields an instruction does not use stay zero.
  always_comb begin
    cw = '0;
    case (op)
      OP_ADDI: begin
        cw.rf_we    = 1'b1;
        cw.rd       = rd;
        cw.ra       = ra;
        cw.alu_op   = ALU_ADD;
        cw.b_imm    = 1'b1;
        cw.imm16    = {{10{ir[5]}}, ir[5:0]};
        cw.flags_we = 1'b1;
      end
      OP_LDI: begin
        cw.rf_we  = 1'b1;
        cw.rd     = rd;
        cw.alu_op = ALU_PASS_B;
        cw.b_imm  = 1'b1;
        cw.imm16  = {8'h00, ir[7:0]};
      end
      OP_LD: begin
        cw.rf_we  = 1'b1;
        cw.rd     = rd;
        cw.ra     = ra;
        cw.mem_re = 1'b1;
      end
      OP_ST: begin
        cw.ra     = ra;
        cw.rb     = rb;
        cw.mem_we = 1'b1;
      end
      default: begin
        if (op >= 4'h1 && op <= 4'h7) begin
          cw.rf_we    = 1'b1;
          cw.rd       = rd;
          cw.ra       = ra;
          cw.rb       = rb;
          cw.alu_op   = op;
          cw.flags_we = 1'b1;
        end
      end
    endcase
  end

  assign illegal = (op == OP_ILL0) || (op == OP_ILL1);
  assign is_mem  = (op == OP_LD) || (op == OP_ST);
  assign is_br   = (op == OP_BR);

endmodule

// File: rtl/core_sequencer.sv
// Fetch/decode/execute controller: owns PC, IR and the registered control word.
// Build option SEQ_SINGLE_STEP_EN adds a `step` input gating each fetch.
module core_sequencer
  import core_seq_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter int              IR_W     = 16,
  parameter int              CW_W     = 46,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clock_50,
  input  logic            reset_n,
  input  logic            run,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic            step,
`endif
  core_seq_if.master      bus,
  output logic [PC_W-1:0] pc,
  output logic [IR_W-1:0] ir,
  output logic            halted,
  output logic            illegal,
  output logic [2:0]      state
);
  seq_state_e      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [IR_W-1:0] ir_q, ir_d;
  logic [CW_W-1:0] cw_q, cw_d;
  logic            halted_q, halted_d;
  logic            illegal_q, illegal_d;
  logic            advance;
  cw_t             dec_cw;
  logic            dec_illegal, dec_is_mem, dec_is_br;
  logic [3:0]      op;

`ifdef SEQ_SINGLE_STEP_EN
  assign advance = run && step;
`else
  assign advance = run;
`endif

  core_decoder u_dec (
    .ir      (ir_q),
    .cw      (dec_cw),
    .illegal (dec_illegal),
    .is_mem  (dec_is_mem),
    .is_br   (dec_is_br)
  );

  assign op = ir_q[15:12];

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      cw_q      <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      cw_q      <= cw_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    cw_d      = cw_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_FETCH: begin
        if (advance) begin
          ir_d    = bus.rom_data;
          pc_d    = pc_q + 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_d = ST_FETCH;
        if (dec_illegal) illegal_d = 1'b1;
        if (dec_is_br) begin
          if (br_taken(ir_q[11:9], bus.c_flag, bus.z_flag, bus.n_flag)) pc_d = ir_q[PC_W-1:0];
        end else if (op == OP_HALT) begin
          halted_d = 1'b1;
          state_d  = ST_HALT;
        end else if (op != OP_NOP && !dec_illegal) begin
          cw_d    = CW_W'(dec_cw);
          state_d = ST_EXECUTE;
        end
      end
      // Memory ops hold the control word until the datapath acknowledges.
      ST_EXECUTE: begin
        if (!dec_is_mem || bus.mem_ack) begin
          cw_d    = '0;
          state_d = ST_FETCH;
        end
      end
      ST_HALT: ;
      default: state_d = ST_FETCH;
    endcase
  end

  assign bus.rom_addr = pc_q;
  assign bus.cw       = cw_t'(cw_q);
  assign pc           = pc_q;
  assign ir           = ir_q;
  assign halted       = halted_q;
  assign illegal      = illegal_q;
  assign state        = state_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: an ISA-level model walks the ROM program and
// queues per-instruction expectations; a monitor checks each retirement.
module tb_core_sequencer;

  typedef struct {
    logic [15:0] ir;
    logic [7:0]  pc_dec;
    logic [7:0]  pc_ret;
    logic [45:0] cw;
    int          lat;
    logic        ill;
    logic        hlt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        run = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
  logic        step = 1'b0;
`endif
  logic [7:0]  pc;
  logic [15:0] ir;
  logic        halted, illegal;
  logic [2:0]  state;
  logic [45:0] cwv;
  logic [15:0] rom [256];

  exp_t        expq[$];
  logic [2:0]  flq[$];
  int          wq[$];
  bit          run_en = 1'b0;
  bit          free_run = 1'b0;
  int          checks = 0;
  int          failures = 0;

  core_seq_if #(.PC_W(8)) bus ();

  core_sequencer #(.PC_W(8), .IR_W(16), .CW_W(46), .RESET_PC(8'h00)) dut (
    .clock_50 (clk),
    .reset_n  (reset_n),
    .run      (run),
`ifdef SEQ_SINGLE_STEP_EN
    .step     (step),
`endif
    .bus      (bus),
    .pc       (pc),
    .ir       (ir),
    .halted   (halted),
    .illegal  (illegal),
    .state    (state)
  );

  always #5 clk = ~clk;

  assign bus.rom_data = rom[bus.rom_addr];
  assign cwv = bus.cw;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // ISA-level reference: executes the program from the reset PC, choosing flags and
  // memory wait per instruction, and records what each retirement must look like.
  task automatic run_model(input int n);
    logic [7:0]  mpc;
    logic [15:0] w;
    logic [3:0]  op;
    logic [2:0]  f, cond;
    logic        ill, t;
    int          wt;
    exp_t        e;
    mpc = 8'h00;
    ill = 1'b0;
    for (int k = 0; k < n; k++) begin
      w  = rom[mpc];
      op = w[15:12];
      f  = 3'($urandom_range(0, 7));
      flq.push_back(f);
      e.ir = w; e.pc_dec = mpc + 8'd1; e.pc_ret = mpc + 8'd1;
      e.cw = '0; e.lat = 1; e.hlt = 1'b0;
      case (op)
        4'h0: ;
        4'hD, 4'hE: ill = 1'b1;
        4'hF: e.hlt = 1'b1;
        4'hC: begin
          cond = w[11:9];
          t = (cond == 3'd0) || (cond == 3'd1 && f[1]) || (cond == 3'd2 && f[2]) ||
              (cond == 3'd3 && f[0]) || (cond == 3'd4 && !f[1]);
          if (t) e.pc_ret = w[7:0];
        end
        4'h8: e.cw = {1'b1, w[11:9], w[8:6], 3'd0, 4'h1, 1'b1, {{10{w[5]}}, w[5:0]},
                      1'b1, 1'b0, 1'b0, 12'h000};
        4'h9: e.cw = {1'b1, w[11:9], 3'd0, 3'd0, 4'h0, 1'b1, {8'h00, w[7:0]},
                      1'b0, 1'b0, 1'b0, 12'h000};
        4'hA: e.cw = {1'b1, w[11:9], w[8:6], 3'd0, 4'h0, 1'b0, 16'h0000,
                      1'b0, 1'b0, 1'b1, 12'h000};
        4'hB: e.cw = {1'b0, 3'd0, w[8:6], w[5:3], 4'h0, 1'b0, 16'h0000,
                      1'b0, 1'b1, 1'b0, 12'h000};
        default: e.cw = {1'b1, w[11:9], w[8:6], w[5:3], op, 1'b0, 16'h0000,
                         1'b1, 1'b0, 1'b0, 12'h000};
      endcase
      if (op >= 4'h1 && op <= 4'hB) e.lat = 2;
      if (op == 4'hA || op == 4'hB) begin
        wt = $urandom_range(0, 5);
        wq.push_back(wt);
        e.lat = 2 + wt;
      end
      e.ill = ill;
      expq.push_back(e);
      mpc = e.pc_ret;
      if (op == 4'hF) break;
    end
  endtask

  // Drivers: run/step throttling, flags presented for DECODE, memory responder.
  int  mem_cnt, mem_wt;
  bit  mem_busy;
  always @(negedge clk) begin
    logic [2:0] f;
    if (!reset_n) begin
      mem_busy = 1'b0;
      bus.mem_ack = 1'b0;
      run = 1'b0;
    end else begin
      run = run_en && ($urandom_range(0, 3) != 0);
`ifdef SEQ_SINGLE_STEP_EN
      step = 1'($urandom_range(0, 1));
`endif
      if (state == 3'd1) begin
        f = (flq.size() != 0) ? flq.pop_front() : 3'($urandom_range(0, 7));
        {bus.n_flag, bus.z_flag, bus.c_flag} = f;
      end
      if (cwv[13] || cwv[12]) begin
        if (!mem_busy) begin
          mem_wt   = (wq.size() != 0) ? wq.pop_front() : 0;
          mem_cnt  = 0;
          mem_busy = 1'b1;
        end
        if (mem_cnt == mem_wt) begin
          bus.mem_ack = 1'b1;
          mem_busy    = 1'b0;
        end else begin
          bus.mem_ack = 1'b0;
          mem_cnt++;
        end
      end else begin
        bus.mem_ack = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor: captures each instruction from DECODE to retirement and scores it.
  bit          in_instr = 1'b0;
  int          lat;
  logic [15:0] cap_ir;
  logic [7:0]  cap_pc;
  logic [45:0] cap_cw;
  bit          cw_unstable;
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      in_instr = 1'b0;
    end else if (state == 3'd1) begin
      in_instr = 1'b1; lat = 1; cap_ir = ir; cap_pc = pc; cap_cw = '0; cw_unstable = 1'b0;
    end else if (in_instr && state == 3'd2) begin
      lat++;
      if (lat == 2) cap_cw = cwv;
      else if (cwv !== cap_cw) cw_unstable = 1'b1;
    end else if (in_instr && (state == 3'd0 || state == 3'd3)) begin
      in_instr = 1'b0;
      if (expq.size() != 0) begin
        e = expq.pop_front();
        chk("ir", cap_ir, e.ir);
        chk("pc_after_fetch", cap_pc, e.pc_dec);
        chk("cw", cap_cw, e.cw);
        chk("cw_held", cw_unstable, 0);
        chk("cw_cleared", cwv, 0);
        chk("cycles", lat, e.lat);
        chk("pc_next", pc, e.pc_ret);
        chk("illegal", illegal, e.ill);
        chk("halted", halted, e.hlt);
      end else if (!free_run) begin
        checks++; failures++;
        $display("FAIL unexpected_retire actual ir=%0h expected none", cap_ir);
      end
    end
  end

  task automatic wait_drain(input string nm, input int budget);
    int n = 0;
    while (expq.size() != 0 && n < budget) begin @(negedge clk); n++; end
    chk({nm, "_drain_remaining"}, expq.size(), 0);
  endtask

  initial begin
    logic [3:0] op;
    logic [11:0] lo;
    int n;
    for (int i = 0; i < 256; i++) begin
      op = 4'($urandom_range(0, 14));
      lo = 12'($urandom);
      rom[i] = {op, lo};
    end
    bus.c_flag = 1'b0; bus.z_flag = 1'b0; bus.n_flag = 1'b0; bus.mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pc", pc, 0);
    chk("rst_ir", ir, 0);
    chk("rst_cw", cwv, 0);
    chk("rst_state", state, 0);
    chk("rst_halted", halted, 0);
    chk("rst_illegal", illegal, 0);

    // Random program, long enough to wrap the PC through 0xFF.
    run_model(400);
    @(negedge clk);
    reset_n = 1'b1;
    run_en  = 1'b1;
    wait_drain("random", 20000);

    // Asynchronous reset landing in the middle of an EXECUTE cycle.
    free_run = 1'b1;
    n = 0;
    while (state != 3'd2 && n < 500) begin @(negedge clk); n++; end
    chk("reach_execute", state, 2);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_cw", cwv, 0);
    chk("async_rst_pc", pc, 0);
    chk("async_rst_state", state, 0);
    run_en = 1'b0;
    flq.delete(); wq.delete(); expq.delete();
    @(negedge clk);
    free_run = 1'b0;

    // Directed program: LDI, R-type, branches (always/never), PC wrap, illegal, ST, LD, HALT.
    rom[8'h00] = 16'h9A05;
    rom[8'h01] = 16'h1298;
    rom[8'h02] = 16'hC0FE;
    rom[8'hFE] = 16'hCA10;
    rom[8'hFF] = 16'hC040;
    rom[8'h40] = 16'hD000;
    rom[8'h41] = 16'hB298;
    rom[8'h42] = 16'hA280;
    rom[8'h43] = 16'hC240;
    rom[8'h44] = 16'hF000;
    run_model(50);
    @(negedge clk);
    reset_n = 1'b1;
    run_en  = 1'b1;
    wait_drain("directed", 2000);
    repeat (10) @(negedge clk);
    chk("halt_state", state, 3);
    chk("halt_sticky", halted, 1);
    chk("halt_cw", cwv, 0);
    chk("illegal_sticky", illegal, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
